// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// load/store stage: one outstanding transaction, MEM priority, bounded IF starvation.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [3:0]  dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic              owner_if;
  logic              discard;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starved;
  logic              grant_if;
  logic              grant_dm;

  assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_if = if_req & (~dm_req | starved);
  assign grant_dm = dm_req & ~grant_if;

  // Gated by rst_n so the stalls read 0 while reset is held.
  assign stall_if  = rst_n & if_req & ~if_ack;
  assign stall_mem = rst_n & dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      discard    <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_ack     <= 1'b0;
      if_rdata   <= 32'h0;
      dm_ack     <= 1'b0;
      dm_rdata   <= 32'h0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (if_flush && owner_if && (state != IDLE)) begin
        discard <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_if) begin
            owner_if   <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 4'b0000;
            mem_addr   <= if_addr;
            mem_wdata  <= 32'h0;
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (grant_dm) begin
            owner_if  <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && !starved) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            // A flush landing in this same cycle must also suppress the ack.
            if (owner_if) begin
              if_rdata <= mem_rdata;
              if_ack   <= ~(discard | if_flush);
            end else begin
              dm_rdata <= mem_rdata;
              dm_ack   <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          discard <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported unified memory between instruction fetch (IF) and the data load/store stage (MEM) of the pipelined RV32I core.
- Serialises requests through one outstanding memory transaction and forwards store byte-enables unchanged from the decode control word.
- Generates per-stage stall signals.
- Gives MEM priority, with a starvation bound for IF, and drops fetch responses that a branch flush has invalidated.

## Interface

Parameters:
- STARVE_MAX, 3: consecutive MEM grants allowed while IF waits before IF is forced ahead.
- CNT_W, 2: width of the starvation counter; it must hold STARVE_MAX.

Ports:
- clk  in  1  rising-edge clock; the block has one clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  32  fetch word address.
- if_flush  in  1  one-cycle pulse that invalidates any fetch in flight.
- if_ack  out  1  one-cycle completion pulse; if_rdata is valid in the same cycle.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  load/store request; held with its fields stable until dm_ack.
- dm_we  in  4  byte enables: 0001 for SB, 0011 for SH, 1111 for SW, 0000 for a load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  32  load data; valid while dm_ack=1.
- mem_req  out  1  memory request; registered.
- mem_we  out  4  byte enables to memory; registered.
- mem_addr  out  32  address to memory; registered.
- mem_wdata  out  32  write data to memory; registered.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  transaction complete; loads and stores both receive it, earliest the cycle after mem_gnt.
- mem_rdata  in  32  read data, valid with mem_rvalid.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM must hold.

## Operation

FSM states: IDLE, ISSUE, WAIT, DONE. A registered owner bit holds IF or DM.

- **IDLE**
  - Samples if_req and dm_req.
  - Only one asserted: grant it.
  - Both asserted: grant DM unless starve_cnt == STARVE_MAX, then grant IF.
  - On a grant, latch the address, we and wdata into the mem_* registers; next state ISSUE.
  - An IF grant always drives mem_we=0000 and mem_wdata=0.
- **ISSUE**
  - mem_req=1 with stable fields.
  - Move to WAIT on mem_gnt.
  - A request is never withdrawn before mem_gnt.
- **WAIT**
  - mem_req=0.
  - On mem_rvalid, register mem_rdata into the owner's rdata; next state DONE.
- **DONE**
  - Pulse the owner's ack for one cycle; next state IDLE.
  - Exception: if the owner is IF and the discard flag is set, no if_ack is produced; clear the flag and go to IDLE.
- **Starvation counter (starve_cnt)**
  - Increments, saturating at STARVE_MAX, on each DM grant made while if_req=1.
  - Clears on each IF grant.
  - Holds otherwise.
- **Flush**
  - if_flush while the owner is IF in ISSUE, WAIT or DONE sets the discard flag. The memory transaction still completes.
  - if_flush in IDLE, or while the owner is DM, has no effect.
  - After a flush, IF may present a new if_addr immediately. It is sampled at the next IDLE.
- **Stalls (combinational)**
  - stall_if = if_req & ~if_ack.
  - stall_mem = dm_req & ~dm_ack.
- **Reset**
  - State IDLE; owner DM; starve_cnt 0; discard flag 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, dm_ack, dm_rdata, stall_if, stall_mem.
  - Stall outputs follow their equations immediately after reset is released.
  - Reset asserted mid-transaction abandons the transaction; the memory is reset on the same rst_n.

## Timing

- Minimum transaction is 4 cycles: IDLE sample, ISSUE with gnt in the same cycle, WAIT with rvalid the next cycle, DONE with ack.
- Latency = 3 + cycles waiting for gnt + cycles from gnt to rvalid − 1.
- Ack falls one cycle after DONE. IDLE then re-arbitrates, so back-to-back transactions are spaced 4 cycles apart at minimum.
- In the ack cycle the requester may deassert its request or present the next one. The arbiter does not sample in DONE.
- mem_rvalid outside WAIT is ignored.
- A new mem_req never starts while a transaction is outstanding.

## Test plan

1. **Single fetch:** reset release, if_req=1 with if_addr=0x100; mem_gnt immediate; mem_rvalid one cycle later with data 0x00500093. Required: if_ack 3 cycles after the IDLE sample, if_rdata=0x00500093, mem_we=0000 throughout.
2. **Simultaneous requests:** if_req and dm_req (SW, dm_we=1111, addr 0x2000, wdata 0xDEADBEEF) held together. Required: DM is served first with mem_we=1111 and mem_wdata=0xDEADBEEF, then IF; stall_if stays high until if_ack.
3. **Starvation bound:** if_req held high while dm_req is re-presented every ack, STARVE_MAX=3. Required: grant order DM, DM, DM, IF, then starve_cnt returns to 0.
4. **Flush in WAIT:** fetch of 0x104 outstanding, if_flush pulsed in WAIT, if_addr then changed to 0x200. Required: no if_ack for 0x104, next mem_addr=0x200, correct if_rdata for 0x200.
5. **Slow memory:** mem_gnt delayed 5 cycles with a load (dm_we=0000) to 0x3000. Required: mem_req and mem_addr stable for all 6 ISSUE cycles, dm_ack once, dm_rdata = mem_rdata.
6. **Reset mid-transaction:** rst_n pulled low during WAIT. Required: all outputs 0 asynchronously; after release a fresh if_req completes normally.
